// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-address sequencer.
//   LINE_OFFSET     : byte-offset bits below the line pointer
//   redirect_src_e  : encoding of the last applied redirect source
//   seq_state_e     : sequencer FSM states
//   clog2_banks()   : bank-index width for a power-of-two bank count
package fetch_pkg;

   localparam int LINE_OFFSET = 4;

   typedef enum logic [1:0] {
      SRC_NONE    = 2'b00,
      SRC_BR      = 2'b01,
      SRC_RESTEER = 2'b10,
      SRC_INIT    = 2'b11
   } redirect_src_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   function automatic int clog2_banks(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fetch_bank_fip.sv
// One bank's line pointer with miss/replay tracking.
//   clk, reset          : clock, synchronous active-high reset
//   load_i, target_i    : redirect load strobe and this bank's new pointer
//   latch_loaded_i      : this bank's line was consumed by the fetch latch
//   cache_miss_i        : this bank's access missed
//   fill_done_i         : fill for this bank completed
//   fip_o, valid_o      : current pointer and "presented for access" flag
module fetch_bank_fip #(
   parameter int FIP_W     = 28,
   parameter int NUM_BANKS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [FIP_W-1:0] target_i,
   input  logic             latch_loaded_i,
   input  logic             cache_miss_i,
   input  logic             fill_done_i,
   output logic [FIP_W-1:0] fip_o,
   output logic             valid_o
);

   logic [FIP_W-1:0] fip_q, fip_d;
   logic             stall_q, stall_d;
   logic             valid_q, valid_d;

   always_comb begin
      fip_d   = fip_q;
      stall_d = stall_q;
      valid_d = valid_q;
      if (load_i) begin
         // Redirect wins: any outstanding miss is abandoned.
         fip_d   = target_i;
         stall_d = 1'b0;
         valid_d = 1'b1;
      end else if (valid_q) begin
         if (cache_miss_i) begin
            // Hold the pointer so it is replayed once the fill lands.
            stall_d = 1'b1;
            valid_d = 1'b0;
         end else if (latch_loaded_i) begin
            // Banks interleave, so this bank's next line is NUM_BANKS ahead.
            fip_d = fip_q + FIP_W'(NUM_BANKS);
         end
      end else if (stall_q && fill_done_i) begin
         stall_d = 1'b0;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fip_q   <= '0;
         stall_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         fip_q   <= fip_d;
         stall_q <= stall_d;
         valid_q <= valid_d;
      end
   end

   assign fip_o   = fip_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_fip_sequencer.sv
// Fetch-address sequencer for an N-bank interleaved instruction cache.
// Arbitrates redirects (init > resteer > taken branch), spreads the
// winning line address across per-bank pointers, and keeps a redirect
// epoch so downstream latches can drop lines fetched before a redirect.
//   clk, reset                      : clock, synchronous active-high reset
//   init_addr/is_init               : init redirect (only source accepted in IDLE)
//   resteer_addr/is_resteer         : writeback resteer
//   br_addr/is_br_taken             : predicted-taken branch
//   latch_loaded/cache_miss/fill_done : per-bank fetch feedback
//   fip_out/fip_valid               : per-bank pointers and valid flags
//   fetch_epoch                     : redirect count modulo 2^EPOCH_W
//   fetch_active                    : sequencer in RUN
//   redirect_src                    : source of the last applied redirect
module fetch_fip_sequencer
   import fetch_pkg::*;
#(
   parameter int NUM_BANKS = 2,
   parameter int FIP_W     = 28,
   parameter int EPOCH_W   = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                init_addr,
   input  logic                       is_init,
   input  logic [31:0]                resteer_addr,
   input  logic                       is_resteer,
   input  logic [31:0]                br_addr,
   input  logic                       is_br_taken,
   input  logic [NUM_BANKS-1:0]       latch_loaded,
   input  logic [NUM_BANKS-1:0]       cache_miss,
   input  logic [NUM_BANKS-1:0]       fill_done,
   output logic [NUM_BANKS*FIP_W-1:0] fip_out,
   output logic [NUM_BANKS-1:0]       fip_valid,
   output logic [EPOCH_W-1:0]         fetch_epoch,
   output logic                       fetch_active,
   output logic [1:0]                 redirect_src
);

   localparam int BANK_W = clog2_banks(NUM_BANKS);

   seq_state_e        state_q, state_d;
   redirect_src_e     src_q, src_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;

   logic              redirect;
   logic [31:0]       sel_addr;
   logic [FIP_W-1:0]  line_addr;
   logic [BANK_W-1:0] line_bank;
   logic              unused_addr_bits;

   // Arbiter plus FSM next state. Resteer and branch only count in RUN.
   always_comb begin
      redirect = 1'b0;
      sel_addr = init_addr;
      src_d    = src_q;
      state_d  = state_q;
      epoch_d  = epoch_q;
      if (is_init) begin
         redirect = 1'b1;
         sel_addr = init_addr;
         src_d    = SRC_INIT;
      end else if (state_q == ST_RUN && is_resteer) begin
         redirect = 1'b1;
         sel_addr = resteer_addr;
         src_d    = SRC_RESTEER;
      end else if (state_q == ST_RUN && is_br_taken) begin
         redirect = 1'b1;
         sel_addr = br_addr;
         src_d    = SRC_BR;
      end
      if (redirect) begin
         state_d = ST_RUN;
         epoch_d = epoch_q + EPOCH_W'(1);
      end
   end

   assign line_addr        = sel_addr[FIP_W+LINE_OFFSET-1:LINE_OFFSET];
   assign line_bank        = line_addr[BANK_W-1:0];
   assign unused_addr_bits = ^sel_addr[LINE_OFFSET-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= SRC_NONE;
         epoch_q <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         epoch_q <= epoch_d;
      end
   end

   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [BANK_W-1:0] ofs;
      logic [FIP_W-1:0]  target;

      // Distance from the redirect line to the first line owned by this
      // bank; the BANK_W-bit subtraction wraps, giving (gi - l) mod N.
      assign ofs    = BANK_W'(gi) - line_bank;
      assign target = line_addr + FIP_W'(ofs);

      fetch_bank_fip #(
         .FIP_W    (FIP_W),
         .NUM_BANKS(NUM_BANKS)
      ) u_bank (
         .clk           (clk),
         .reset         (reset),
         .load_i        (redirect),
         .target_i      (target),
         .latch_loaded_i(latch_loaded[gi]),
         .cache_miss_i  (cache_miss[gi]),
         .fill_done_i   (fill_done[gi]),
         .fip_o         (fip_out[gi*FIP_W +: FIP_W]),
         .valid_o       (fip_valid[gi])
      );
   end

   assign fetch_epoch  = epoch_q;
   assign fetch_active = (state_q == ST_RUN);
   assign redirect_src = src_q;

endmodule

// File: tb/tb_fetch_fip_sequencer.sv
module tb_fetch_fip_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] init_addr, resteer_addr, br_addr;
   logic        is_init, is_resteer, is_br_taken;
   logic [1:0]  lat2, miss2, fill2;
   logic [3:0]  lat4, miss4, fill4;

   logic [55:0]  fo2;
   logic [1:0]   fv2;
   logic [2:0]   ep2;
   logic         act2;
   logic [1:0]   src2;
   logic [111:0] fo4;
   logic [3:0]   fv4;
   logic [2:0]   ep4;
   logic         act4;
   logic [1:0]   src4;

   fetch_fip_sequencer #(.NUM_BANKS(2), .FIP_W(28), .EPOCH_W(3)) dut2 (
      .clk(clk), .reset(reset),
      .init_addr(init_addr), .is_init(is_init),
      .resteer_addr(resteer_addr), .is_resteer(is_resteer),
      .br_addr(br_addr), .is_br_taken(is_br_taken),
      .latch_loaded(lat2), .cache_miss(miss2), .fill_done(fill2),
      .fip_out(fo2), .fip_valid(fv2), .fetch_epoch(ep2),
      .fetch_active(act2), .redirect_src(src2)
   );

   fetch_fip_sequencer #(.NUM_BANKS(4), .FIP_W(28), .EPOCH_W(3)) dut4 (
      .clk(clk), .reset(reset),
      .init_addr(init_addr), .is_init(is_init),
      .resteer_addr(resteer_addr), .is_resteer(is_resteer),
      .br_addr(br_addr), .is_br_taken(is_br_taken),
      .latch_loaded(lat4), .cache_miss(miss4), .fill_done(fill4),
      .fip_out(fo4), .fip_valid(fv4), .fetch_epoch(ep4),
      .fetch_active(act4), .redirect_src(src4)
   );

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: index 0 is the 2-bank instance, 1 the 4-bank one.
   localparam int unsigned MASK = 32'h0FFF_FFFF;
   int unsigned m_fip [2][4];
   bit          m_val [2][4];
   bit          m_stl [2][4];
   int          m_ep  [2];
   int          m_src [2];
   bit          m_run [2];

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int n;
         bit take;
         int unsigned a, l;
         n = (k == 0) ? 2 : 4;
         if (reset) begin
            for (int b = 0; b < 4; b++) begin
               m_fip[k][b] = 0; m_val[k][b] = 0; m_stl[k][b] = 0;
            end
            m_ep[k] = 0; m_src[k] = 0; m_run[k] = 0;
            continue;
         end
         take = is_init || (m_run[k] && (is_resteer || is_br_taken));
         if (take) begin
            if (is_init)         begin a = init_addr;    m_src[k] = 3; end
            else if (is_resteer) begin a = resteer_addr; m_src[k] = 2; end
            else                 begin a = br_addr;      m_src[k] = 1; end
            l = (a >> 4) & MASK;
            for (int b = 0; b < n; b++) begin
               m_fip[k][b] = (l + ((b + n - int'(l % n)) % n)) & MASK;
               m_val[k][b] = 1;
               m_stl[k][b] = 0;
            end
            m_ep[k]  = (m_ep[k] + 1) % 8;
            m_run[k] = 1;
         end else begin
            for (int b = 0; b < n; b++) begin
               bit lt, ms, fd;
               lt = (k == 0) ? lat2[b]  : lat4[b];
               ms = (k == 0) ? miss2[b] : miss4[b];
               fd = (k == 0) ? fill2[b] : fill4[b];
               if (m_val[k][b]) begin
                  if (ms) begin
                     m_stl[k][b] = 1; m_val[k][b] = 0;
                  end else if (lt) begin
                     m_fip[k][b] = (m_fip[k][b] + n) & MASK;
                  end
               end else if (m_stl[k][b] && fd) begin
                  m_stl[k][b] = 0; m_val[k][b] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      logic [127:0] ef;
      logic [3:0]   ev;
      for (int k = 0; k < 2; k++) begin
         int n;
         n  = (k == 0) ? 2 : 4;
         ef = '0;
         ev = '0;
         for (int b = 0; b < n; b++) begin
            ef[b*28 +: 28] = 28'(m_fip[k][b]);
            ev[b]          = m_val[k][b];
         end
         if (k == 0) begin
            chk("n2_fip",    {72'd0, fo2}, ef);
            chk("n2_valid",  {126'd0, fv2}, {124'd0, ev});
            chk("n2_epoch",  {125'd0, ep2}, 128'(m_ep[0]));
            chk("n2_active", {127'd0, act2}, {127'd0, m_run[0]});
            chk("n2_src",    {126'd0, src2}, 128'(m_src[0]));
         end else begin
            chk("n4_fip",    {16'd0, fo4}, ef);
            chk("n4_valid",  {124'd0, fv4}, {124'd0, ev});
            chk("n4_epoch",  {125'd0, ep4}, 128'(m_ep[1]));
            chk("n4_active", {127'd0, act4}, {127'd0, m_run[1]});
            chk("n4_src",    {126'd0, src4}, 128'(m_src[1]));
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check_all();
      $display("cyc=%0d rst=%b init=%b rs=%b br=%b fip2=%h v2=%b ep2=%0d fip4=%h v4=%b ep4=%0d",
               cyc, reset, is_init, is_resteer, is_br_taken, fo2, fv2, ep2, fo4, fv4, ep4);
   endtask

   task automatic clear_in();
      reset = 0; is_init = 0; is_resteer = 0; is_br_taken = 0;
      init_addr = 0; resteer_addr = 0; br_addr = 0;
      lat2 = 0; miss2 = 0; fill2 = 0; lat4 = 0; miss4 = 0; fill4 = 0;
   endtask

   initial begin
      clear_in();
      reset = 1;
      cycle();
      cycle();
      chk("rst_fip2",   {72'd0, fo2}, 128'd0);
      chk("rst_valid4", {124'd0, fv4}, 128'd0);
      chk("rst_active", {127'd0, act2}, 128'd0);
      chk("rst_src",    {126'd0, src2}, 128'd0);

      // Branch in IDLE is ignored.
      clear_in(); is_br_taken = 1; br_addr = 32'h0000_4000;
      cycle();
      chk("idle_br_active", {127'd0, act2}, 128'd0);

      clear_in(); is_init = 1; init_addr = 32'h0000_1010;
      cycle();
      chk("init_b0",  {100'd0, fo2[27:0]},  128'h102);
      chk("init_b1",  {100'd0, fo2[55:28]}, 128'h101);
      chk("init_v",   {126'd0, fv2}, 128'h3);
      chk("init_ep",  {125'd0, ep2}, 128'd1);
      chk("init_src", {126'd0, src2}, 128'h3);
      chk("init_act", {127'd0, act2}, 128'd1);

      clear_in(); is_init = 1; init_addr = 32'h0000_0050;
      cycle();
      chk("n4_b0", {100'd0, fo4[27:0]},   128'h8);
      chk("n4_b1", {100'd0, fo4[55:28]},  128'h5);
      chk("n4_b2", {100'd0, fo4[83:56]},  128'h6);
      chk("n4_b3", {100'd0, fo4[111:84]}, 128'h7);
      clear_in(); lat4 = 4'b0010;
      cycle();
      chk("n4_adv_b1", {100'd0, fo4[55:28]}, 128'h9);
      chk("n4_adv_b0", {100'd0, fo4[27:0]},  128'h8);

      clear_in(); is_init = 1; init_addr = 32'h0000_1010;
      cycle();
      clear_in(); miss2 = 2'b01; lat2 = 2'b01;
      cycle();
      chk("miss_hold", {100'd0, fo2[27:0]}, 128'h102);
      chk("miss_v0",   {127'd0, fv2[0]}, 128'd0);
      clear_in(); fill2 = 2'b01;
      cycle();
      chk("fill_v0",   {127'd0, fv2[0]}, 128'd1);
      chk("fill_b0",   {100'd0, fo2[27:0]}, 128'h102);

      clear_in();
      is_init = 1; init_addr = 32'h2000;
      is_resteer = 1; resteer_addr = 32'h3000;
      is_br_taken = 1; br_addr = 32'h4000;
      cycle();
      chk("prio_src", {126'd0, src2}, 128'h3);
      chk("prio_b0",  {100'd0, fo2[27:0]},  128'h200);
      chk("prio_b1",  {100'd0, fo2[55:28]}, 128'h201);

      clear_in(); miss2 = 2'b01;
      cycle();
      clear_in(); is_resteer = 1; resteer_addr = 32'h3000;
      cycle();
      chk("rs_stall_v",   {126'd0, fv2}, 128'h3);
      chk("rs_stall_src", {126'd0, src2}, 128'h2);
      chk("rs_stall_b0",  {100'd0, fo2[27:0]}, 128'h300);

      clear_in(); is_init = 1; init_addr = 32'hFFFF_FFF0;
      cycle();
      chk("wrap_b1_pre", {100'd0, fo2[55:28]}, 128'hFFF_FFFF);
      clear_in(); lat2 = 2'b10;
      cycle();
      chk("wrap_b1", {100'd0, fo2[55:28]}, 128'h1);

      // Epoch wrap: reset, init (epoch 1), then seven branches -> 8 -> 0.
      clear_in(); reset = 1;
      cycle();
      clear_in(); is_init = 1; init_addr = 32'h100;
      cycle();
      for (int i = 0; i < 7; i++) begin
         clear_in(); is_br_taken = 1; br_addr = $urandom;
         cycle();
      end
      chk("epoch_wrap2", {125'd0, ep2}, 128'd0);
      chk("epoch_wrap4", {125'd0, ep4}, 128'd0);

      // Reset mid-stall with a branch pending, then a lone branch in IDLE.
      clear_in(); miss2 = 2'b10;
      cycle();
      clear_in(); reset = 1; is_br_taken = 1; br_addr = 32'h8000;
      cycle();
      chk("rstmid_fip", {72'd0, fo2}, 128'd0);
      chk("rstmid_v",   {126'd0, fv2}, 128'd0);
      chk("rstmid_act", {127'd0, act2}, 128'd0);
      chk("rstmid_src", {126'd0, src2}, 128'd0);
      chk("rstmid_ep",  {125'd0, ep2}, 128'd0);
      clear_in(); is_br_taken = 1; br_addr = 32'h8000;
      cycle();
      chk("postrst_act", {127'd0, act2}, 128'd0);
      chk("postrst_v",   {126'd0, fv2}, 128'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         clear_in();
         reset        = ($urandom % 60) == 0;
         is_init      = ($urandom % 12) == 0;
         is_resteer   = ($urandom % 9) == 0;
         is_br_taken  = ($urandom % 6) == 0;
         init_addr    = $urandom;
         resteer_addr = $urandom;
         br_addr      = $urandom;
         lat2  = 2'($urandom); miss2 = 2'($urandom & $urandom); fill2 = 2'($urandom);
         lat4  = 4'($urandom); miss4 = 4'($urandom & $urandom); fill4 = 4'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
